// File: rtl/cla_ctrl_pkg.sv
// Shared types and helpers for the CLA adder arbiter: FSM states,
// width derivation and the round-robin requester pick.
package cla_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    localparam int MAX_REQ = 8;

    function automatic int cla_width(input int in_size, input int depth);
        int w;
        w = 1;
        for (int i = 0; i < depth; i++) begin
            w = w * in_size;
        end
        return w;
    endfunction

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Scanning from the far end down lets the index closest to ptr win.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input int n,
                                           input logic [2:0] ptr);
        logic [2:0] pick;
        int idx;
        pick = ptr;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % n;
            if (valid[idx]) begin
                pick = 3'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cla_adder.sv
// Combinational WIDTH-bit adder: bitwise propagate/generate feeding the CLA tree.
module cla_adder
    import cla_ctrl_pkg::*;
#(
    parameter int INPUT_SIZE = 4,
    parameter int DEPTH      = 2,
    localparam int WIDTH     = cla_width(INPUT_SIZE, DEPTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;
    logic             gp;
    logic             gg;

    assign p = a ^ b;
    assign g = a & b;

    cla_tree #(
        .INPUT_SIZE(INPUT_SIZE),
        .DEPTH     (DEPTH)
    ) u_tree (
        .p  (p),
        .g  (g),
        .cin(cin),
        .c  (c),
        .gp (gp),
        .gg (gg)
    );

    assign sum  = p ^ c;
    assign cout = gg | (gp & cin);

endmodule

// File: rtl/cla_tree.sv
// Recursive carry-lookahead tree: per-bit carry-ins plus group propagate/generate,
// built from INPUT_SIZE-wide lookahead groups over DEPTH levels.
module cla_tree
    import cla_ctrl_pkg::*;
#(
    parameter int INPUT_SIZE = 4,
    parameter int DEPTH      = 2,
    localparam int W         = cla_width(INPUT_SIZE, DEPTH)
) (
    input  logic [W-1:0] p,
    input  logic [W-1:0] g,
    input  logic         cin,
    output logic [W-1:0] c,
    output logic         gp,
    output logic         gg
);

    if (DEPTH == 1) begin : g_leaf
        // Group terms stay independent of cin so the parent level never sees a loop.
        always_comb begin
            logic acc;
            acc = 1'b0;
            for (int i = 0; i < W; i++) begin
                acc = g[i] | (p[i] & acc);
            end
            gg = acc;
            gp = &p;
        end

        always_comb begin
            logic carry;
            carry = cin;
            for (int i = 0; i < W; i++) begin
                c[i]  = carry;
                carry = g[i] | (p[i] & carry);
            end
        end
    end else begin : g_node
        localparam int SW = W / INPUT_SIZE;

        logic [INPUT_SIZE-1:0] sub_p;
        logic [INPUT_SIZE-1:0] sub_g;
        logic [INPUT_SIZE-1:0] sub_c;

        for (genvar j = 0; j < INPUT_SIZE; j++) begin : g_sub
            cla_tree #(
                .INPUT_SIZE(INPUT_SIZE),
                .DEPTH     (DEPTH - 1)
            ) u_sub (
                .p  (p[j*SW +: SW]),
                .g  (g[j*SW +: SW]),
                .cin(sub_c[j]),
                .c  (c[j*SW +: SW]),
                .gp (sub_p[j]),
                .gg (sub_g[j])
            );
        end

        cla_tree #(
            .INPUT_SIZE(INPUT_SIZE),
            .DEPTH     (1)
        ) u_top (
            .p  (sub_p),
            .g  (sub_g),
            .cin(cin),
            .c  (sub_c),
            .gp (gp),
            .gg (gg)
        );
    end

endmodule

// File: rtl/cla_add_arbiter.sv
// Round-robin arbiter sharing one CLA adder among NUM_REQ requesters,
// with a one-cycle execute stage and a registered response slot.
module cla_add_arbiter
    import cla_ctrl_pkg::*;
#(
    parameter int INPUT_SIZE = 4,
    parameter int DEPTH      = 2,
    parameter int NUM_REQ    = 4,
    localparam int WIDTH     = cla_width(INPUT_SIZE, DEPTH),
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf,
    output logic [ID_W-1:0]          rsp_id
);

    localparam int MSB = WIDTH - 1;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    op_id;
    logic [ID_W-1:0]    next_ptr;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_cin;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_cin;
    logic               sel_sub;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [MAX_REQ-1:0] valid_ext;
    logic               any_valid;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
    end

    assign any_valid = |req_valid;
    assign grant     = ID_W'(rr_pick(valid_ext, NUM_REQ, 3'(ptr)));

    // Only the granted slice is muxed through, so other requesters' operands never reach state.
    always_comb begin
        sel_a   = req_a[int'(grant)*WIDTH +: WIDTH];
        sel_b   = req_b[int'(grant)*WIDTH +: WIDTH];
        sel_cin = req_cin[grant];
        sel_sub = req_sub[grant];
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && any_valid) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign next_ptr = (op_id == ID_W'(NUM_REQ - 1)) ? '0 : op_id + ID_W'(1);

    cla_adder #(
        .INPUT_SIZE(INPUT_SIZE),
        .DEPTH     (DEPTH)
    ) u_adder (
        .a   (op_a),
        .b   (op_b),
        .cin (op_cin),
        .sum (sum),
        .cout(cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a   <= sel_a;
                        op_b   <= sel_sub ? ~sel_b : sel_b;
                        op_cin <= sel_sub | sel_cin;
                        op_id  <= grant;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= sum;
                    rsp_cout  <= cout;
                    rsp_ovf   <= (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    ptr       <= next_ptr;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
